// File: rtl/monitor_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | monitor_pkg : shared types, ASCII codes and hex helpers for the    |
// |               UART debug monitor                                   |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
package monitor_pkg;

  typedef enum logic [2:0] {
    P_IDLE    = 3'd0,
    P_W_ADDR  = 3'd1,
    P_W_DATA  = 3'd2,
    P_R_START = 3'd3,
    P_R_END   = 3'd4,
    P_DUMP    = 3'd5
  } parser_state_e;

  localparam logic [7:0] ASCII_Q     = 8'h71;
  localparam logic [7:0] ASCII_W     = 8'h77;
  localparam logic [7:0] ASCII_R     = 8'h72;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0d;
  localparam logic [7:0] ASCII_LF    = 8'h0a;

  function automatic logic is_hex(input logic [7:0] c);
    return ((c >= 8'h30) && (c <= 8'h39)) ||
           ((c >= 8'h61) && (c <= 8'h66)) ||
           ((c >= 8'h41) && (c <= 8'h46));
  endfunction

  function automatic logic [3:0] hex2nib(input logic [7:0] c);
    logic [7:0] v;
    if (c <= 8'h39)      v = c - 8'h30;
    else if (c >= 8'h61) v = c - 8'h57;
    else                 v = c - 8'h37;
    return v[3:0];
  endfunction

  function automatic logic [7:0] nib2hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h57 + {4'd0, n});
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_rx : 8N1 receiver with 2-flop synchronizer and mid-bit sample |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module uart_rx #(
  parameter int CLKS_PER_BIT = 20
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic       valid_o,
  output logic [7:0] data_o
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [1:0]    sync_q;
  logic          prev_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          valid_q;
  logic [7:0]    data_q;

  logic rx_s, fall, tick_half, tick_bit;
  assign rx_s      = sync_q[1];
  assign fall      = prev_q & ~rx_s;
  assign tick_half = (cnt_q == HALF_LAST);
  assign tick_bit  = (cnt_q == BIT_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fall) state_d = S_START;
      S_START: if (tick_half) state_d = rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (tick_bit && (bit_q == 3'd7)) state_d = S_STOP;
      S_STOP:  if (tick_bit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      prev_q  <= rx_s;
      valid_q <= 1'b0;
      case (state_q)
        S_START: cnt_q <= tick_half ? '0 : cnt_q + 1'b1;
        S_DATA: begin
          if (tick_bit) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (tick_bit) begin
            cnt_q <= '0;
            // A low stop bit is a framing error: drop the byte silently.
            if (rx_s) begin
              valid_q <= 1'b1;
              data_q  <= shift_q;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          cnt_q <= '0;
          bit_q <= '0;
        end
      endcase
    end
  end

  always_comb begin
    valid_o = valid_q;
    data_o  = data_q;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_tx : 8N1 transmitter, byte handshake via start_i / busy_o     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module uart_tx #(
  parameter int CLKS_PER_BIT = 20
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       busy_o
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_SEND = 1'b1;

  logic          state_q, state_d;
  logic [9:0]    shift_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    bit_q;

  logic tick;
  assign tick = (cnt_q == BIT_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_SEND;
      S_SEND:  if (tick && (bit_q == 4'd9)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '1;
      cnt_q   <= '0;
      bit_q   <= '0;
    end else if (state_q == S_IDLE) begin
      cnt_q <= '0;
      bit_q <= '0;
      if (start_i) shift_q <= {1'b1, data_i, 1'b0};
    end else if (tick) begin
      cnt_q   <= '0;
      shift_q <= {1'b1, shift_q[9:1]};
      bit_q   <= bit_q + 4'd1;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    tx_o   = (state_q == S_SEND) ? shift_q[0] : 1'b1;
    busy_o = (state_q == S_SEND);
  end

endmodule
`default_nettype wire

// File: rtl/fpga_dram_top.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fpga_dram_top : UART debug monitor - hex write/dump of word memory |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
module fpga_dram_top #(
  parameter int CLKS_PER_BIT = 20,
  parameter int MEM_WORDS    = 1024
) (
  input  logic clkin,
  input  logic rst_n,
  input  logic rx,
  output logic tx
);
  import monitor_pkg::*;

  localparam int AW = $clog2(MEM_WORDS);

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_i(clkin), .rst_ni(rst_n), .rx_i(rx), .valid_o(rx_valid), .data_o(rx_data)
  );

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk_i(clkin), .rst_ni(rst_n), .start_i(tx_start), .data_i(tx_data),
    .tx_o(tx), .busy_o(tx_busy)
  );

  parser_state_e state_q, state_d;
  logic [2:0]    digit_q;
  logic [27:0]   shreg_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   cur_q;
  logic [31:0]   end_q;
  logic          single_q;
  logic          fetch_q;
  logic [31:0]   word_q;
  logic [3:0]    char_q;
  logic [31:0]   mem_q [MEM_WORDS];

  logic        w_is_q, w_digit, w_collect, w_last_digit, w_last_word, w_send, w_line_done;
  logic [31:0] w_shift_nxt;

  assign w_is_q       = rx_valid && (rx_data == ASCII_Q);
  assign w_digit      = rx_valid && (rx_data != ASCII_SPACE) && is_hex(rx_data);
  assign w_collect    = (state_q == P_W_ADDR) || (state_q == P_W_DATA) ||
                        (state_q == P_R_START) || (state_q == P_R_END);
  assign w_last_digit = w_collect && w_digit && (digit_q == 3'd7);
  assign w_shift_nxt  = {shreg_q, hex2nib(rx_data)};
  // Unsigned distance keeps the loop correct even when end sits near 2^32.
  assign w_last_word  = single_q || ((end_q - cur_q) < 32'd4);
  assign w_send       = (state_q == P_DUMP) && !fetch_q && !tx_busy && !w_is_q;
  assign w_line_done  = w_send && (char_q == 4'd9);

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) state_q <= P_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (w_is_q) begin
      state_d = P_IDLE;
    end else begin
      case (state_q)
        P_IDLE: begin
          if (rx_valid && (rx_data == ASCII_W)) state_d = P_W_ADDR;
          if (rx_valid && (rx_data == ASCII_R)) state_d = P_R_START;
        end
        P_W_ADDR:  if (w_last_digit) state_d = P_W_DATA;
        P_W_DATA:  if (w_last_digit) state_d = P_IDLE;
        P_R_START: if (w_last_digit) state_d = P_R_END;
        P_R_END:   if (w_last_digit) state_d = P_DUMP;
        P_DUMP:    if (w_line_done && w_last_word) state_d = P_IDLE;
        default:   state_d = P_IDLE;
      endcase
    end
  end

  always_comb begin
    tx_start = w_send;
    if (char_q < 4'd8)       tx_data = nib2hex(word_q[31:28]);
    else if (char_q == 4'd8) tx_data = ASCII_CR;
    else                     tx_data = ASCII_LF;
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      digit_q  <= '0;
      shreg_q  <= '0;
      addr_q   <= '0;
      cur_q    <= '0;
      end_q    <= '0;
      single_q <= 1'b0;
      fetch_q  <= 1'b0;
      word_q   <= '0;
      char_q   <= '0;
    end else begin
      if (w_is_q) begin
        digit_q <= '0;
      end else if ((state_q == P_IDLE) && rx_valid &&
                   ((rx_data == ASCII_W) || (rx_data == ASCII_R))) begin
        digit_q <= '0;
      end else if (w_collect && w_digit) begin
        digit_q <= digit_q + 3'd1;
        shreg_q <= w_shift_nxt[27:0];
        if (digit_q == 3'd7) begin
          case (state_q)
            P_W_ADDR:  addr_q <= w_shift_nxt[AW+1:2];
            P_R_START: cur_q  <= w_shift_nxt;
            P_R_END: begin
              end_q    <= w_shift_nxt;
              single_q <= (w_shift_nxt < cur_q);
              fetch_q  <= 1'b1;
            end
            default: ;
          endcase
        end
      end

      if (state_q == P_DUMP) begin
        if (fetch_q) begin
          word_q  <= mem_q[cur_q[AW+1:2]];
          fetch_q <= 1'b0;
          char_q  <= '0;
        end else if (w_send) begin
          char_q <= char_q + 4'd1;
          if (char_q < 4'd8) word_q <= word_q << 4;
          if (char_q == 4'd9) begin
            cur_q   <= cur_q + 32'd4;
            fetch_q <= 1'b1;
          end
        end
      end
    end
  end

  // Memory has no reset so its contents survive a board reset.
  always_ff @(posedge clkin) begin
    if ((state_q == P_W_DATA) && w_last_digit) mem_q[addr_q] <= w_shift_nxt;
  end

endmodule
`default_nettype wire

// File: tb/tb_fpga_dram_top.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fpga_dram_top : bit-banged UART bench with a word-memory model  |
// | Revision         : 1.0                                             |
// +--------------------------------------------------------------------+
module tb_fpga_dram_top;

  localparam int CPB = 20;
  localparam int MW  = 1024;

  logic clkin = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;
  logic tx;

  always #5 clkin = ~clkin;

  fpga_dram_top #(.CLKS_PER_BIT(CPB), .MEM_WORDS(MW)) dut (
    .clkin(clkin), .rst_n(rst_n), .rx(rx), .tx(tx)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] model_mem [MW];
  logic [7:0]  txq [$];
  logic [7:0]  rxq [$];
  logic [7:0]  exp_q [$];
  int frames_started = 0;
  int q_snap = 0;
  int rst_events = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge rst_n) rst_events++;

  // Decode frames on tx, mid-bit sampling on the falling clock edge.
  initial begin
    forever begin
      @(negedge clkin);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        logic [7:0] b;
        logic ok;
        int rs;
        rs = rst_events;
        frames_started++;
        repeat (CPB / 2) @(negedge clkin);
        ok = (tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clkin);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clkin);
        if (ok && tx === 1'b1 && rs == rst_events) txq.push_back(b);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clkin);
      if (dut.rx_valid === 1'b1) begin
        #1;
        rxq.push_back(dut.rx_data);
        if (dut.rx_data == 8'h71) q_snap = frames_started;
      end
    end
  end

  function automatic logic [7:0] hexch(input logic [3:0] n, input bit up);
    if (n < 10) return 8'h30 + {4'd0, n};
    return (up ? 8'h41 : 8'h61) + {4'd0, n} - 8'd10;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit bad_stop = 1'b0);
    @(negedge clkin);
    rx = 1'b0;
    repeat (CPB) @(negedge clkin);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clkin);
    end
    rx = ~bad_stop;
    repeat (CPB) @(negedge clkin);
    rx = 1'b1;
    if (bad_stop) repeat (CPB) @(negedge clkin);
  endtask

  task automatic send_hex32(input logic [31:0] v, input bit up);
    for (int i = 7; i >= 0; i--) send_byte(hexch(v[i*4 +: 4], up));
  endtask

  task automatic cmd_write(input logic [31:0] addr, input logic [31:0] data, input bit up);
    send_byte(8'h71);
    send_byte(8'h77);
    send_hex32(addr, up);
    send_byte(8'h20);
    send_hex32(data, up);
    model_mem[int'((addr >> 2) % MW)] = data;
  endtask

  task automatic cmd_read(input logic [31:0] s, input logic [31:0] e);
    send_byte(8'h71);
    send_byte(8'h72);
    send_hex32(s, 1'b0);
    send_hex32(e, 1'b1);
  endtask

  task automatic add_word(input logic [31:0] a);
    logic [31:0] w;
    w = model_mem[int'((a >> 2) % MW)];
    for (int i = 7; i >= 0; i--) exp_q.push_back(hexch(w[i*4 +: 4], 1'b0));
    exp_q.push_back(8'h0d);
    exp_q.push_back(8'h0a);
  endtask

  task automatic build_exp(input logic [31:0] s, input logic [31:0] e);
    exp_q.delete();
    if (e < s) add_word(s);
    else for (longint a = s; a <= e; a += 4) add_word(32'(a));
  endtask

  task automatic wait_tx(input int n, input int budget);
    int cnt = 0;
    while (txq.size() < n && cnt < budget) begin
      @(negedge clkin);
      cnt++;
    end
  endtask

  task automatic check_mem_all(input string tag);
    int bad = 0;
    for (int i = 0; i < MW; i++) if (dut.mem_q[i] !== model_mem[i]) bad++;
    check(tag, bad, 0);
  endtask

  task automatic run_read(input string tag, input logic [31:0] s, input logic [31:0] e);
    txq.delete();
    build_exp(s, e);
    cmd_read(s, e);
    wait_tx(exp_q.size(), exp_q.size() * 10 * CPB + 200);
    repeat (25 * CPB) @(negedge clkin);
    check({tag, "_count"}, txq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_char%0d", tag, i), (i < txq.size()) ? txq[i] : 8'hxx, exp_q[i]);
    check({tag, "_idle"}, dut.state_q, 0);
  endtask

  initial begin
    logic [31:0] a, d, s, e;
    int base, n;
    for (int i = 0; i < MW; i++) model_mem[i] = '0;

    repeat (5) @(negedge clkin);
    check("reset_tx", tx, 1);
    check("reset_state", dut.state_q, 0);
    check("reset_digit", dut.digit_q, 0);
    check("reset_rx_valid", dut.rx_valid, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clkin);

    rxq.delete();
    send_byte(8'h71);
    repeat (5) @(negedge clkin);
    check("rx_count", rxq.size(), 1);
    check("rx_byte", (rxq.size() > 0) ? rxq[0] : 8'hxx, 8'h71);
    rxq.delete();
    send_byte(8'h5a, 1'b1);
    repeat (2 * CPB) @(negedge clkin);
    check("rx_badstop", rxq.size(), 0);
    check("tx_quiet", txq.size(), 0);

    cmd_write(32'h0, 32'h33333333, 1'b0);
    repeat (3) @(negedge clkin);
    check("write_word0", dut.mem_q[0], 32'h33333333);
    check_mem_all("write_others");

    run_read("read9", 32'h0, 32'h20);

    d = $urandom;
    cmd_write(32'h00001004, d, 1'b1);
    repeat (3) @(negedge clkin);
    check("wrap_word1", dut.mem_q[1], d);
    check_mem_all("wrap_others");
    run_read("wrap_read", 32'h4, 32'h0);

    for (int k = 0; k < 2; k++) begin
      a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(2, 7)) << 2) | 32'($urandom_range(0, 3));
      d = $urandom;
      cmd_write(a, d, k[0]);
      repeat (3) @(negedge clkin);
      check_mem_all($sformatf("rand_write%0d", k));
    end
    s = (32'($urandom_range(0, 6)) << 2) | 32'($urandom_range(0, 3));
    e = s + (32'($urandom_range(0, 2)) << 2);
    run_read("rand_read", s, e);

    txq.delete();
    build_exp(32'h0, 32'h1c);
    base = frames_started;
    cmd_read(32'h0, 32'h1c);
    wait_tx(2, 4000);
    check("abort_started", txq.size() >= 2, 1);
    send_byte(8'h71);
    repeat (25 * CPB) @(negedge clkin);
    n = q_snap - base;
    check("abort_count", txq.size(), n);
    check("abort_early", n < exp_q.size(), 1);
    for (int i = 0; i < txq.size() && i < exp_q.size(); i++)
      check($sformatf("abort_char%0d", i), txq[i], exp_q[i]);
    check("abort_idle", dut.state_q, 0);
    run_read("after_abort", 32'h8, 32'h8);

    txq.delete();
    cmd_read(32'h0, 32'h10);
    wait_tx(1, 4000);
    check("rst_dump_started", txq.size() >= 1, 1);
    repeat (3 * CPB + 3) @(negedge clkin);
    rst_n = 1'b0;
    #1;
    check("rst_tx_high", tx, 1);
    check("rst_state", dut.state_q, 0);
    repeat (3) @(negedge clkin);
    rst_n = 1'b1;
    repeat (12 * CPB) @(negedge clkin);
    txq.delete();
    base = frames_started;
    repeat (30 * CPB) @(negedge clkin);
    check("rst_quiet_bytes", txq.size(), 0);
    check("rst_quiet_frames", frames_started - base, 0);
    check_mem_all("rst_mem_kept");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
